// File: rtl/bist_sig_analyzer.sv
// bist_sig_analyzer
//   Multiple-input signature register (MISR) for logic BIST. Compacts a
//   programmable number of circuit-under-test responses into an N+1 bit
//   signature, then compares it against a golden value.
//
// Parameters
//   N     : signature / response bus is [N:0]
//   POLY  : MISR feedback tap mask, [N:0]
//   PW    : pattern-count width (max session 2^PW-1 patterns)
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous reset, active low
//   start      : begin a session (accepted in IDLE or DONE only)
//   n_patterns : responses to compact, latched on accepted start
//   golden     : expected signature, sampled in CHECK
//   resp_valid : resp is valid this cycle (used in RUN only)
//   resp       : circuit-under-test response
//   pat_req    : high in RUN; upstream pattern source advances while high
//   busy       : high in RUN and CHECK
//   done       : high in DONE
//   pass       : signature == golden, valid while done
//   signature  : current MISR contents
//   pat_count  : responses compacted this session
module bist_sig_analyzer #(
  parameter int          N    = 16,
  parameter logic [N:0]  POLY = 17'h1A011,
  parameter int          PW   = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [PW-1:0] n_patterns,
  input  logic [N:0]    golden,
  input  logic          resp_valid,
  input  logic [N:0]    resp,
  output logic          pat_req,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [N:0]    signature,
  output logic [PW-1:0] pat_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [N:0]    sig_q, sig_nxt;
  logic [PW-1:0] cnt_q, cnt_nxt, cnt_inc;
  logic [PW-1:0] n_lat_q, n_lat_nxt;
  logic          pass_q, pass_nxt;
  logic          pat_req_q, busy_q, done_q;
  logic          fb;

  assign fb      = ^(sig_q & POLY);
  assign cnt_inc = cnt_q + PW'(1);

  always_comb begin
    state_nxt = state;
    sig_nxt   = sig_q;
    cnt_nxt   = cnt_q;
    n_lat_nxt = n_lat_q;
    pass_nxt  = pass_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          sig_nxt   = '0;
          cnt_nxt   = '0;
          n_lat_nxt = n_patterns;
          pass_nxt  = 1'b0;
          // An empty session skips compaction and compares the cleared MISR.
          state_nxt = (n_patterns == '0) ? CHECK : RUN;
        end
      end
      RUN: begin
        if (resp_valid) begin
          sig_nxt = {sig_q[N-1:0], fb} ^ resp;
          cnt_nxt = cnt_inc;
          if (cnt_inc == n_lat_q) state_nxt = CHECK;
        end
      end
      CHECK: begin
        pass_nxt  = (sig_q == golden);
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with
  // the state register rather than being decoded after it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      sig_q     <= '0;
      cnt_q     <= '0;
      n_lat_q   <= '0;
      pass_q    <= 1'b0;
      pat_req_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      sig_q     <= sig_nxt;
      cnt_q     <= cnt_nxt;
      n_lat_q   <= n_lat_nxt;
      pass_q    <= pass_nxt;
      pat_req_q <= (state_nxt == RUN);
      busy_q    <= (state_nxt == RUN) || (state_nxt == CHECK);
      done_q    <= (state_nxt == DONE);
    end
  end

  assign pat_req   = pat_req_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;
  assign pat_count = cnt_q;

endmodule

// File: doc/bist_sig_analyzer.md
BIST_SIG_ANALYZER -- requirements
Module: bist_sig_analyzer

Interface
REQ-001 SHALL have parameter N, default 16; data/signature bus width is N+1 bits, [N:0], matching the LFSR pattern bus.
REQ-002 SHALL have parameter POLY, default 17'h1A011; [N:0] MISR feedback tap mask (bits 16,15,13,4,0).
REQ-003 SHALL have parameter PW, default 16; pattern-count width.
REQ-004 SHALL have port clk, input, 1 bit; single clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit; asynchronous, active-low reset (0 = reset).
REQ-006 SHALL have port start, input, 1 bit; begin a session; sampled in IDLE or DONE only.
REQ-007 SHALL have port n_patterns, input, PW bits; number of responses to compact; sampled on accepted start.
REQ-008 SHALL have port golden, input, N+1 bits; expected signature; sampled in CHECK.
REQ-009 SHALL have port resp_valid, input, 1 bit; resp is valid this cycle.
REQ-010 SHALL have port resp, input, N+1 bits; circuit-under-test response.
REQ-011 SHALL have port pat_req, output, 1 bit; high in RUN; upstream LFSR/CUT advances while high.
REQ-012 SHALL have port busy, output, 1 bit; high in RUN and CHECK.
REQ-013 SHALL have port done, output, 1 bit; high in DONE.
REQ-014 SHALL have port pass, output, 1 bit; compare result; valid while done=1.
REQ-015 SHALL have port signature, output, N+1 bits; current MISR contents.
REQ-016 SHALL have port pat_count, output, PW bits; responses compacted this session.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, CHECK, DONE; all outputs registered.
REQ-018 IDLE/DONE with start=1: SHALL clear signature and pat_count to 0, latch n_patterns, go to RUN (or CHECK if latched n_patterns==0).
REQ-019 IDLE/DONE with start=0: SHALL hold state, signature, pat_count, pass.
REQ-020 RUN with resp_valid=1: SHALL update signature = {signature[N-1:0], fb} XOR resp, fb = XOR-reduce(signature AND POLY), and increment pat_count.
REQ-021 RUN with resp_valid=0: SHALL hold signature and pat_count; no timeout.
REQ-022 RUN: SHALL go to CHECK on the accepted response that makes pat_count equal the latched n_patterns; later resp_valid is ignored.
REQ-023 CHECK: SHALL last exactly one cycle, set pass = (signature == golden), go to DONE.
REQ-024 start SHALL be ignored in RUN and CHECK.
REQ-025 resp_valid SHALL be ignored outside RUN.
REQ-026 pat_count SHALL never wrap; the maximum session is 2^PW-1 patterns.
REQ-027 Latency: done SHALL rise two cycles after the last accepted response edge (RUN->CHECK, then CHECK->DONE).

Reset
REQ-028 reset=0 SHALL immediately force IDLE, signature=0, pat_count=0, pass=0, done=0, busy=0, pat_req=0, regardless of clk.
REQ-029 reset asserted mid-RUN or mid-CHECK SHALL abort the session without producing done; after release, the block waits in IDLE for start.
REQ-030 The first rising clk edge after reset release SHALL be usable (start accepted on that edge).

Verification
REQ-031 Reset release, then start, n_patterns=2, resp 17'h00001 for two valid cycles, golden=17'h00002 -> signature 1 then 2; done=1, pass=1, pat_count=2.
REQ-032 Same as REQ-031 with golden=17'h00003 -> done=1, pass=0, signature=17'h00002.
REQ-033 n_patterns=0, start -> IDLE->CHECK->DONE; signature=0; pass=1 iff golden=0.
REQ-034 n_patterns=3, resp_valid gaps (1,0,0,1,1), extra resp_valid after the third accepted response, start pulsed during RUN -> exactly 3 compactions, start ignored, done two cycles after the third accepted response.
REQ-035 reset=0 asynchronously mid-RUN (between clk edges) -> all outputs 0 immediately; a new start after release runs a clean session matching REQ-031.
REQ-036 start in DONE -> signature and pat_count cleared, new session completes; back-to-back sessions give identical signatures for identical stimuli.
